// File: rtl/data_memory_responder.sv
// Multi-cycle data memory serving CPU load/store requests; stalls the core via BUSYWAIT.
// Request captured at E0, completes at E0+LATENCY, then one DONE cycle with BUSYWAIT low.
module data_memory_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int LATENCY    = 5
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  READ,
  input  logic                  WRITE,
  input  logic [ADDR_WIDTH-1:0] ADDRESS,
  input  logic [DATA_WIDTH-1:0] WRITEDATA,
  output logic [DATA_WIDTH-1:0] READDATA,
  output logic                  BUSYWAIT,
  output logic                  PROTOCOL_ERR
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int         DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  op_wr_q, op_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  busy;
  logic                  commit;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    busy    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Stall combinationally so the PC holds before the capture edge.
        busy = READ ^ WRITE;
        if (READ && WRITE) begin
          err_d = 1'b1;
        end else if (READ ^ WRITE) begin
          addr_d  = ADDRESS;
          wdata_d = WRITEDATA;
          op_wr_d = WRITE;
          cnt_d   = CNT_INIT;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        busy = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          state_d = ST_DONE;
          if (!op_wr_q) rdata_d = mem_q[addr_q];
        end
      end
      ST_DONE: begin
        // Request lines ignored here so a held request cannot retrigger.
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (commit && op_wr_q) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign BUSYWAIT     = busy && !RESET;
  assign READDATA     = rdata_q;
  assign PROTOCOL_ERR = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: default LATENCY=5 instance plus a LATENCY=1 instance.
module tb_data_memory_responder;

  logic       CLK = 1'b0;
  logic       RESET, READ, WRITE;
  logic [7:0] ADDRESS, WRITEDATA, READDATA;
  logic       BUSYWAIT, PROTOCOL_ERR;

  logic       f_READ, f_WRITE;
  logic [7:0] f_ADDRESS, f_WRITEDATA, f_READDATA;
  logic       f_BUSYWAIT, f_ERR;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  data_memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(5)) u_dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE), .ADDRESS(ADDRESS),
    .WRITEDATA(WRITEDATA), .READDATA(READDATA), .BUSYWAIT(BUSYWAIT),
    .PROTOCOL_ERR(PROTOCOL_ERR)
  );

  data_memory_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(8), .LATENCY(1)) u_fast (
    .CLK(CLK), .RESET(RESET), .READ(f_READ), .WRITE(f_WRITE), .ADDRESS(f_ADDRESS),
    .WRITEDATA(f_WRITEDATA), .READDATA(f_READDATA), .BUSYWAIT(f_BUSYWAIT),
    .PROTOCOL_ERR(f_ERR)
  );

  // Stimulus only: runs one access from a negedge, reports what it saw, ends in IDLE.
  task automatic run_access(input bit w, input logic [7:0] a, input logic [7:0] d,
                            output bit same_cycle, output int busy_cycles,
                            output logic [7:0] rd);
    READ = !w; WRITE = w; ADDRESS = a; WRITEDATA = d;
    #1;
    same_cycle  = BUSYWAIT;
    busy_cycles = BUSYWAIT ? 1 : 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (BUSYWAIT) busy_cycles++;
      else break;
    end
    rd = READDATA;
    READ = 1'b0; WRITE = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1; READ = 1'b1; ADDRESS = 8'h10;
    repeat (2) @(negedge CLK);
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSYWAIT); end
    checks++; if (READDATA !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h expected 00", READDATA); end
    checks++; if (PROTOCOL_ERR !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", PROTOCOL_ERR); end
    checks++; if (f_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL reset_fast_busy: got %b expected 0", f_BUSYWAIT); end
    READ = 1'b0; RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_read_basic();
    bit same; int n; logic [7:0] rd;
    run_access(1'b0, 8'h10, 8'h00, same, n, rd);
    checks++; if (same !== 1'b1) begin errors++; $display("FAIL read_same_cycle_busy: got %b expected 1", same); end
    checks++; if (n != 6) begin errors++; $display("FAIL read_busy_cycles: got %0d expected 6", n); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL read_10_data: got %h expected 00", rd); end
  endtask

  task automatic test_write_read();
    bit same; int n; logic [7:0] rd;
    run_access(1'b1, 8'h2A, 8'h5C, same, n, rd);
    checks++; if (n != 6) begin errors++; $display("FAIL write_busy_cycles: got %0d expected 6", n); end
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL write_keeps_rdata: got %h expected 00", rd); end
    run_access(1'b0, 8'h2A, 8'h00, same, n, rd);
    checks++; if (n != 6) begin errors++; $display("FAIL readback_busy_cycles: got %0d expected 6", n); end
    checks++; if (rd !== 8'h5C) begin errors++; $display("FAIL readback_2a: got %h expected 5c", rd); end
    run_access(1'b1, 8'h2A, 8'h11, same, n, rd);
    checks++; if (READDATA !== 8'h5C) begin errors++; $display("FAIL write_same_addr_rdata: got %h expected 5c", READDATA); end
  endtask

  task automatic test_ignore_changes();
    bit same; int n; logic [7:0] rd;
    WRITE = 1'b1; ADDRESS = 8'h03; WRITEDATA = 8'h77;
    @(negedge CLK);
    ADDRESS = 8'h04; WRITEDATA = 8'hFF;
    for (int i = 0; i < 20 && BUSYWAIT; i++) @(negedge CLK);
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL ignore_timeout: busy=%b expected 0", BUSYWAIT); end
    WRITE = 1'b0;
    @(negedge CLK);
    // Request dropped after capture must still complete.
    WRITE = 1'b1; ADDRESS = 8'h05; WRITEDATA = 8'h31;
    @(negedge CLK);
    WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    for (int i = 0; i < 20 && BUSYWAIT; i++) @(negedge CLK);
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL drop_timeout: busy=%b expected 0", BUSYWAIT); end
    @(negedge CLK);
    run_access(1'b0, 8'h03, 8'h00, same, n, rd);
    checks++; if (rd !== 8'h77) begin errors++; $display("FAIL ignore_addr03: got %h expected 77", rd); end
    run_access(1'b0, 8'h04, 8'h00, same, n, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL ignore_addr04: got %h expected 00", rd); end
    run_access(1'b0, 8'h05, 8'h00, same, n, rd);
    checks++; if (rd !== 8'h31) begin errors++; $display("FAIL dropped_addr05: got %h expected 31", rd); end
  endtask

  task automatic test_reset_mid();
    bit same; int n; logic [7:0] rd;
    WRITE = 1'b1; ADDRESS = 8'h08; WRITEDATA = 8'h99;
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    #1;
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", BUSYWAIT); end
    checks++; if (READDATA !== 8'h00) begin errors++; $display("FAIL midreset_rdata: got %h expected 00", READDATA); end
    @(negedge CLK);
    WRITE = 1'b0; RESET = 1'b0;
    @(negedge CLK);
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL midreset_idle: got %b expected 0", BUSYWAIT); end
    run_access(1'b0, 8'h08, 8'h00, same, n, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL midreset_addr08: got %h expected 00", rd); end
    checks++; if (n != 6) begin errors++; $display("FAIL midreset_read_cycles: got %0d expected 6", n); end
    run_access(1'b0, 8'h05, 8'h00, same, n, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL midreset_mem_clear: got %h expected 00", rd); end
  endtask

  task automatic test_protocol_err();
    bit same; int n; logic [7:0] rd;
    READ = 1'b1; WRITE = 1'b1; ADDRESS = 8'h2A; WRITEDATA = 8'hEE;
    #1;
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL both_busy_comb: got %b expected 0", BUSYWAIT); end
    @(negedge CLK);
    checks++; if (PROTOCOL_ERR !== 1'b1) begin errors++; $display("FAIL both_err_set: got %b expected 1", PROTOCOL_ERR); end
    checks++; if (BUSYWAIT !== 1'b0) begin errors++; $display("FAIL both_busy_after: got %b expected 0", BUSYWAIT); end
    READ = 1'b0; WRITE = 1'b0;
    @(negedge CLK);
    run_access(1'b0, 8'h2A, 8'h00, same, n, rd);
    checks++; if (rd !== 8'h00) begin errors++; $display("FAIL both_no_write: got %h expected 00", rd); end
    checks++; if (PROTOCOL_ERR !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", PROTOCOL_ERR); end
    RESET = 1'b1;
    #1;
    checks++; if (PROTOCOL_ERR !== 1'b0) begin errors++; $display("FAIL err_cleared: got %b expected 0", PROTOCOL_ERR); end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    f_WRITE = 1'b1; f_ADDRESS = 8'h07; f_WRITEDATA = 8'h42;
    @(negedge CLK);
    @(negedge CLK);
    f_WRITE = 1'b0;
    @(negedge CLK);
    f_READ = 1'b1;
    #1;
    checks++; if (f_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL b2b_req_busy: got %b expected 1", f_BUSYWAIT); end
    @(negedge CLK);
    checks++; if (f_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL b2b_busy_state: got %b expected 1", f_BUSYWAIT); end
    @(negedge CLK);
    checks++; if (f_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL b2b_done1: got %b expected 0", f_BUSYWAIT); end
    checks++; if (f_READDATA !== 8'h42) begin errors++; $display("FAIL b2b_rdata: got %h expected 42", f_READDATA); end
    @(negedge CLK);
    checks++; if (f_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL b2b_retrigger: got %b expected 1", f_BUSYWAIT); end
    @(negedge CLK);
    checks++; if (f_BUSYWAIT !== 1'b1) begin errors++; $display("FAIL b2b_second_busy: got %b expected 1", f_BUSYWAIT); end
    @(negedge CLK);
    checks++; if (f_BUSYWAIT !== 1'b0) begin errors++; $display("FAIL b2b_done2: got %b expected 0", f_BUSYWAIT); end
    f_READ = 1'b0;
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b1; READ = 1'b0; WRITE = 1'b0; ADDRESS = '0; WRITEDATA = '0;
    f_READ = 1'b0; f_WRITE = 1'b0; f_ADDRESS = '0; f_WRITEDATA = '0;
    test_reset();
    test_read_basic();
    test_write_read();
    test_ignore_changes();
    test_reset_mid();
    test_protocol_err();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
